// File: rtl/mcd_mem_arb.sv
// mcd_mem_arb: shares one 16-bit synchronous SRAM port between the four MCD
// memory requesters (0 bios, 1 prg ram, 2 bram, 3 pcm ram).
// A grant runs IDLE -> ISSUE -> WAIT -> DONE. The access is latched at the
// grant. The requester sees a one-cycle ack in DONE, and read data is valid
// on rd_dato in that cycle.
// Optional macro MCD_ARB_PCM_PRIO_EN: requester 3 (pcm) takes strict priority
// over the round-robin search whenever its req is high at the IDLE decision.
module mcd_mem_arb #(
    parameter int ADDR_W = 22,
    parameter int RD_LAT = 2,
    parameter int WR_CYC = 1
) (
    input  logic                  clk,
    input  logic                  map_rst_n,
    input  logic [3:0]            req,
    input  logic [3:0]            req_we,
    input  logic [7:0]            req_be,
    input  logic [4*ADDR_W-1:0]   req_addr,
    input  logic [63:0]           req_dati,
    output logic [3:0]            ack,
    output logic [15:0]           rd_dato,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [15:0]           mem_dati,
    output logic                  mem_we_hi,
    output logic                  mem_we_lo,
    output logic                  mem_oe,
    input  logic [15:0]           mem_dato,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [2:0] RD_CNT = 3'(RD_LAT);
    localparam logic [2:0] WR_CNT = 3'(WR_CYC);

    state_t              state;
    logic [1:0]          rr;
    logic [1:0]          idx;
    logic                we_l;
    logic [1:0]          be_l;
    logic [2:0]          cnt;

    logic [1:0]          sel;
    logic                sel_we;
    logic [1:0]          sel_be;
    logic [ADDR_W-1:0]   sel_addr;
    logic [15:0]         sel_dat;

    // First requester with req high, searching upward from p (mod 4).
    // The lowest offset from p is assigned last and therefore wins.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] c;
        pick = p;
        for (int k = 3; k >= 0; k--) begin
            c = p + 2'(k);
            if (r[c]) pick = c;
        end
`ifdef MCD_ARB_PCM_PRIO_EN
        if (r[3]) pick = 2'd3;
`else
`endif
    endfunction

    // Winner of the IDLE decision and its request fields; bios can never write.
    always_comb begin
        sel      = pick(req, rr);
        sel_we   = req_we[sel] & (sel != 2'd0);
        sel_be   = req_be[sel*2 +: 2];
        sel_addr = req_addr[sel*ADDR_W +: ADDR_W];
        sel_dat  = req_dati[sel*16 +: 16];
    end

    // Access sequencer: grant, strobe timing, read capture, ack and rr update.
    always_ff @(posedge clk) begin
        if (!map_rst_n) begin
            state     <= IDLE;
            rr        <= '0;
            idx       <= '0;
            we_l      <= 1'b0;
            be_l      <= '0;
            cnt       <= '0;
            ack       <= '0;
            rd_dato   <= '0;
            mem_addr  <= '0;
            mem_dati  <= '0;
            mem_we_hi <= 1'b0;
            mem_we_lo <= 1'b0;
            mem_oe    <= 1'b0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        idx       <= sel;
                        we_l      <= sel_we;
                        be_l      <= sel_be;
                        mem_addr  <= sel_addr;
                        mem_dati  <= sel_dat;
                        cnt       <= sel_we ? WR_CNT : RD_CNT;
                        mem_oe    <= !sel_we;
                        mem_we_hi <= sel_we & sel_be[1];
                        mem_we_lo <= sel_we & sel_be[0];
                        state     <= ISSUE;
                    end
                end
                ISSUE, WAIT: begin
                    // Strobes stay up for cnt cycles counted from ISSUE; the
                    // cycle where cnt reaches 0 is the read-data cycle.
                    cnt       <= cnt - 3'd1;
                    mem_oe    <= !we_l && (cnt > 3'd1);
                    mem_we_hi <= we_l && be_l[1] && (cnt > 3'd1);
                    mem_we_lo <= we_l && be_l[0] && (cnt > 3'd1);
                    state     <= WAIT;
                    if (state == WAIT && cnt == 3'd0) begin
                        if (!we_l) rd_dato <= mem_dato;
                        ack[idx] <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    rr    <= idx + 2'd1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mcd_mem_arb.sv
// Scoreboard bench for mcd_mem_arb: stimulus pushes expected accesses, and a
// negedge monitor pops and checks one entry per ack.
module tb_mcd_mem_arb;

    localparam int AW     = 22;
    localparam int RD_LAT = 2;
    localparam int WR_CYC = 2;

    logic            clk = 1'b0;
    logic            map_rst_n = 1'b0;
    logic [3:0]      req = '0;
    logic [3:0]      req_we = '0;
    logic [7:0]      req_be = '0;
    logic [4*AW-1:0] req_addr = '0;
    logic [63:0]     req_dati = '0;
    logic [3:0]      ack;
    logic [15:0]     rd_dato;
    logic [AW-1:0]   mem_addr;
    logic [15:0]     mem_dati;
    logic            mem_we_hi, mem_we_lo, mem_oe;
    logic [15:0]     mem_dato;
    logic            busy;

    always #5 clk = ~clk;

    mcd_mem_arb #(.ADDR_W(AW), .RD_LAT(RD_LAT), .WR_CYC(WR_CYC)) dut (
        .clk(clk), .map_rst_n(map_rst_n), .req(req), .req_we(req_we),
        .req_be(req_be), .req_addr(req_addr), .req_dati(req_dati),
        .ack(ack), .rd_dato(rd_dato), .mem_addr(mem_addr), .mem_dati(mem_dati),
        .mem_we_hi(mem_we_hi), .mem_we_lo(mem_we_lo), .mem_oe(mem_oe),
        .mem_dato(mem_dato), .busy(busy)
    );

    // SRAM model: content 0xBEEF at 0x123, otherwise addr[15:0]^0x5A5A,
    // presented RD_LAT cycles after the cycle mem_oe samples the address.
    function automatic logic [15:0] mem_rd(input logic [AW-1:0] a);
        if (a == 22'h123) return 16'hBEEF;
        return a[15:0] ^ 16'h5A5A;
    endfunction

    logic [15:0] pipe [RD_LAT];
    always @(posedge clk) begin
        if (!map_rst_n) begin
            for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= mem_oe ? mem_rd(mem_addr) : 16'h0000;
            for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign mem_dato = pipe[RD_LAT-1];

    typedef struct {
        int            idx;
        bit            rd;
        logic [15:0]   data;
        logic [AW-1:0] addr;
        logic [15:0]   dati;
        int            oe_n;
        int            whi_n;
        int            wlo_n;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int acks_seen = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Monitor: counts strobe cycles per access and checks each ack against the queue.
    int            oe_n = 0, whi_n = 0, wlo_n = 0, issue_t = 0;
    logic          busy_q = 1'b0;
    logic [AW-1:0] seen_addr = '0;
    logic [15:0]   seen_dati = '0;
    exp_t          e;
    always @(negedge clk) begin
        cyc++;
        if (!map_rst_n) begin
            oe_n = 0; whi_n = 0; wlo_n = 0;
        end else begin
            if (busy && !busy_q) issue_t = cyc;
            if (mem_oe) begin oe_n++; seen_addr = mem_addr; end
            if (mem_we_hi) whi_n++;
            if (mem_we_lo) wlo_n++;
            if (mem_we_hi || mem_we_lo) begin seen_addr = mem_addr; seen_dati = mem_dati; end
            if (ack != 4'b0000) begin
                acks_seen++;
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ack got=%b want=none", ack);
                end else begin
                    e = q.pop_front();
                    chk("ack_onehot", 32'(ack), 32'(1) << e.idx);
                    chk("latency", cyc - issue_t, e.rd ? RD_LAT + 1 : WR_CYC + 1);
                    chk("oe_cycles", oe_n, e.oe_n);
                    chk("we_hi_cycles", whi_n, e.whi_n);
                    chk("we_lo_cycles", wlo_n, e.wlo_n);
                    if (e.rd) chk("rd_dato", 32'(rd_dato), 32'(e.data));
                    if (e.oe_n + e.whi_n + e.wlo_n > 0) chk("mem_addr", 32'(seen_addr), 32'(e.addr));
                    if (e.whi_n + e.wlo_n > 0) chk("mem_dati", 32'(seen_dati), 32'(e.dati));
                end
                oe_n = 0; whi_n = 0; wlo_n = 0;
            end
        end
        busy_q = busy;
    end

    task automatic set_req(input int i, input bit we, input logic [1:0] be,
                           input logic [AW-1:0] a, input logic [15:0] d);
        req_we[i]         = we;
        req_be[i*2 +: 2]  = be;
        req_addr[i*AW +: AW] = a;
        req_dati[i*16 +: 16] = d;
        req[i]            = 1'b1;
    endtask

    task automatic push(input int i, input bit rd, input logic [15:0] data,
                        input logic [AW-1:0] a, input logic [15:0] d,
                        input int o, input int wh, input int wl);
        exp_t x;
        x.idx = i; x.rd = rd; x.data = data; x.addr = a; x.dati = d;
        x.oe_n = o; x.whi_n = wh; x.wlo_n = wl;
        q.push_back(x);
    endtask

    task automatic wait_acks(input int target, input string nm);
        int t = 0;
        while (acks_seen < target && t < 300) begin
            @(negedge clk); #1; t++;
        end
        if (acks_seen < target) begin
            checks++; errors++;
            $display("FAIL timeout_%s got=%0d want=%0d", nm, acks_seen, target);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        map_rst_n = 1'b0;
        req = '0;
        repeat (2) begin @(negedge clk); #1; end
        map_rst_n = 1'b1;
        @(negedge clk); #1;
    endtask

    logic [15:0] rr_data [4] = '{16'h5B5A, 16'h5B5B, 16'h5B58, 16'h5B59};
    int          order   [8];
    int          base;
    int          t;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_oe", 32'(mem_oe), 32'h0);
        chk("rst_we", 32'({mem_we_hi, mem_we_lo}), 32'h0);
        chk("rst_rd_dato", 32'(rd_dato), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        map_rst_n = 1'b1;
        @(negedge clk); #1;

        // Single read from prg ram
        base = acks_seen;
        push(1, 1'b1, 16'hBEEF, 22'h123, 16'h0, RD_LAT, 0, 0);
        set_req(1, 1'b0, 2'b00, 22'h123, 16'h0);
        wait_acks(base + 1, "single_read");
        req = '0;

        // Low-byte write from bram
        base = acks_seen;
        push(2, 1'b0, 16'h0, 22'h1F, 16'h55AA, 0, 0, WR_CYC);
        set_req(2, 1'b1, 2'b01, 22'h1F, 16'h55AA);
        wait_acks(base + 1, "byte_write");
        req = '0;

        // Round-robin from a fresh reset (rr would be 3 otherwise)
        do_reset();
`ifdef MCD_ARB_PCM_PRIO_EN
        order = '{3, 3, 3, 3, 3, 3, 3, 3};
`else
        order = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
        for (int k = 0; k < 8; k++)
            push(order[k], 1'b1, rr_data[order[k]], 22'h100 + 22'(order[k]), 16'h0, RD_LAT, 0, 0);
        base = acks_seen;
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 2'b00, 22'h100 + 22'(i), 16'h0);
        wait_acks(base + 8, "round_robin");
        req = '0;

        // Bios write request is forced to a read
        base = acks_seen;
        push(0, 1'b1, 16'h58FA, 22'h2A0, 16'h0, RD_LAT, 0, 0);
        set_req(0, 1'b1, 2'b11, 22'h2A0, 16'hFFFF);
        wait_acks(base + 1, "bios_write");
        req = '0;

        // High-byte write at the top address from pcm
        base = acks_seen;
        push(3, 1'b0, 16'h0, 22'h3FFFFF, 16'hA5C3, 0, WR_CYC, 0);
        set_req(3, 1'b1, 2'b10, 22'h3FFFFF, 16'hA5C3);
        wait_acks(base + 1, "hi_write");
        req = '0;

        // Write with no byte enables still acks
        base = acks_seen;
        push(1, 1'b0, 16'h0, 22'h55, 16'h1234, 0, 0, 0);
        set_req(1, 1'b1, 2'b00, 22'h55, 16'h1234);
        wait_acks(base + 1, "zero_be");
        req = '0;

        // Reset during WAIT of a read: access dropped, no ack
        set_req(1, 1'b0, 2'b00, 22'h77, 16'h0);
        t = 0;
        while (!mem_oe && t < 50) begin @(negedge clk); #1; t++; end
        chk("mid_rst_oe_seen", 32'(mem_oe), 32'h1);
        @(negedge clk); #1;
        map_rst_n = 1'b0;
        req = '0;
        @(negedge clk); #1;
        chk("mid_rst_oe", 32'(mem_oe), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_ack", 32'(ack), 32'h0);
        chk("mid_rst_we", 32'({mem_we_hi, mem_we_lo}), 32'h0);
        map_rst_n = 1'b1;
        repeat (6) begin @(negedge clk); #1; end
        base = acks_seen;
        push(3, 1'b1, 16'h5A59, 22'h3, 16'h0, RD_LAT, 0, 0);
        set_req(3, 1'b0, 2'b00, 22'h3, 16'h0);
        wait_acks(base + 1, "after_reset");
        req = '0;

        repeat (10) @(negedge clk);
        #1;
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
